// File: rtl/secure_mem_ctrl.sv
// secure_mem_ctrl: access controller for the on-chip secure key memory.
// Checks a fixed per-address policy on every single-beat request, then
// issues the memory access, waits for read data with a timeout, and
// returns one response per request. Response data is scrubbed to zero
// once it has been handed over, and write data is only on the bus
// during the write cycle.
module secure_mem_ctrl #(
  parameter  int WIDTH   = 256,
  parameter  int LENGTH  = 8,
  parameter  int TIMEOUT = 4,
  localparam int AW      = $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  // request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic             req_priv,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  // memory port
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wrData,
  input  logic [WIDTH-1:0] mem_rdData,
  input  logic             mem_rdData_valid
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_RWAIT = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // captured request
  logic             r_write;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_priv;

  // read timeout counter
  logic [CW-1:0]    r_cnt;

  // registered outputs
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_err;
  logic             r_mem_rd_en;
  logic             r_mem_wr_en;
  logic [AW-1:0]    r_mem_addr;
  logic [WIDTH-1:0] r_mem_wrData;

  // next values of the registered outputs
  logic             w_req_ready_nxt;
  logic             w_rsp_valid_nxt;
  logic             w_mem_rd_en_nxt;
  logic             w_mem_wr_en_nxt;
  logic [AW-1:0]    w_mem_addr_nxt;
  logic [WIDTH-1:0] w_mem_wrData_nxt;

  // effective request: the values being latched this cycle on accept,
  // otherwise the values latched earlier
  logic             w_accept;
  logic             w_write;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_priv;
  logic             w_denied;
  logic             w_timeout;
  logic             w_rsp_hs;

  // Access policy. Entries 0..3 hold ID, watermark and two keys and are
  // never writable; keys (2,3) are readable only by the privileged
  // engine; the remaining entries are writable only by it.
  function automatic logic f_denied(input logic          wr,
                                    input logic [AW-1:0] addr,
                                    input logic          priv);
    logic is_key;
    logic is_low;
    is_key = (addr == AW'(2)) || (addr == AW'(3));
    is_low = (addr <  AW'(4));
    if (wr) begin
      f_denied = is_low || !priv;
    end else begin
      f_denied = is_key && !priv;
    end
  endfunction

  assign w_accept  = (r_state == S_IDLE) && r_req_ready && req_valid;
  assign w_write   = w_accept ? req_write : r_write;
  assign w_addr    = w_accept ? req_addr  : r_addr;
  assign w_wdata   = w_accept ? req_wdata : r_wdata;
  assign w_priv    = w_accept ? req_priv  : r_priv;
  assign w_denied  = f_denied(w_write, w_addr, w_priv);
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready;

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign mem_rd_en  = r_mem_rd_en;
  assign mem_wr_en  = r_mem_wr_en;
  assign mem_addr   = r_mem_addr;
  assign mem_wrData = r_mem_wrData;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_denied) begin
            w_state_nxt = S_RESP;
          end else if (w_write) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
          end
        end
      end
      S_WR:    w_state_nxt = S_RESP;
      S_RD:    w_state_nxt = S_RWAIT;
      S_RWAIT: begin
        if (mem_rdData_valid || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state, so every output comes from a flop.
  always_comb begin
    w_req_ready_nxt  = (w_state_nxt == S_IDLE);
    w_rsp_valid_nxt  = (w_state_nxt == S_RESP);
    w_mem_rd_en_nxt  = (w_state_nxt == S_RD) || (w_state_nxt == S_RWAIT);
    w_mem_wr_en_nxt  = (w_state_nxt == S_WR);
    w_mem_addr_nxt   = '0;
    w_mem_wrData_nxt = '0;
    if (w_mem_rd_en_nxt || w_mem_wr_en_nxt) begin
      w_mem_addr_nxt = w_addr;
    end
    if (w_mem_wr_en_nxt) begin
      w_mem_wrData_nxt = w_wdata;
    end
  end

  // Output registers; reset drops every enable at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      r_mem_wr_en  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wrData <= '0;
    end else begin
      r_req_ready  <= w_req_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_mem_rd_en  <= w_mem_rd_en_nxt;
      r_mem_wr_en  <= w_mem_wr_en_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wrData <= w_mem_wrData_nxt;
    end
  end

  // Request capture; write data is scrubbed when the response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_priv  <= 1'b0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_priv  <= req_priv;
    end else if (w_rsp_hs) begin
      r_wdata <= '0;
    end
  end

  // Read timeout counter: counts RWAIT cycles, zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((r_state == S_RWAIT) && !mem_rdData_valid && !w_timeout) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Response register: loaded on the way into RESP, cleared on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_denied) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        S_WR: begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b0;
        end
        S_RWAIT: begin
          if (mem_rdData_valid) begin
            r_rsp_data <= mem_rdData;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
          end
        end
        default: begin
          r_rsp_data <= r_rsp_data;
          r_rsp_err  <= r_rsp_err;
        end
      endcase
    end
  end

endmodule
